func_sweep_ctrl: RTL and testbench
==================================

// Module: func_sweep_ctrl
// PURPOSE
//  Sequencer that drives a small combinational function unit (N_IN inputs, 1 output)
//   through all 2^N_IN input vectors, one at a time.
//  Each vector is held for a settle window, then the output is sampled into a truth-table register.
//  Sits between the function unit and a host/bench; the host starts a sweep and reads back the table.
// PARAMETERS
//  N_IN    4  number of function inputs; the sweep covers 2^N_IN vectors (N_IN 1..6)
//  SETTLE  1  cycles a vector is held before its sampling cycle (>=1)
// PORTS
//  clk       in   1          single clock, rising edge
//  rst_n     in   1          asynchronous, active-low reset
//  start     in   1          begin a sweep; honoured only in IDLE
//  abort     in   1          stop the sweep; return to IDLE, no done pulse
//  vec_o     out  N_IN       drive to the function unit inputs, MSB first ({a,b,c,d} = vec_o)
//  f_i       in   1          function unit output
//  busy      out  1          high from the start edge until DONE is left
//  done      out  1          one-cycle pulse when the sweep completes
//  table_o   out  2^N_IN     bit i = f_i observed with vec_o == i
//  ones_cnt  out  N_IN+1     number of vectors with f_i == 1 (minterm count)
// BEHAVIOUR
//  Reset: state IDLE; vec_o=0, busy=0, done=0, table_o=0, ones_cnt=0, settle counter=0.
//  States: IDLE -> WAIT -> SAMPLE -> (WAIT | DONE) -> IDLE.
//  IDLE, start=1 at an edge: vec_o<=0, table_o<=0, ones_cnt<=0, counter<=SETTLE-1, busy<=1; go to WAIT.
//  WAIT: counter decrements each cycle. When it reads 0, go to SAMPLE.
//  SAMPLE, at the edge leaving it:
//   - table_o[vec_o]<=f_i; ones_cnt<=ones_cnt+f_i.
//   - If vec_o==2^N_IN-1, go to DONE.
//   - Otherwise vec_o<=vec_o+1, counter<=SETTLE-1, go to WAIT.
//  vec_o is stable for SETTLE+1 cycles per vector; each vector costs exactly SETTLE+1 cycles.
//  DONE: done=1 for exactly one cycle, busy=1; next edge goes to IDLE with busy<=0.
//  Latency: done is high in the cycle after edge 2^N_IN*(SETTLE+1), counted from the start edge.
//   For defaults (16 vectors, SETTLE=1) this is 32 edges.
//  vec_o never wraps: the last value 2^N_IN-1 is held through DONE and returns to 0 only on the next start.
//  table_o and ones_cnt hold their values in IDLE until the next start; the host reads them after done.
//  ones_cnt cannot overflow: its width holds 2^N_IN.
//  start while not in IDLE is ignored, including in DONE.
//  abort in WAIT/SAMPLE/DONE: go to IDLE next edge, busy<=0, done stays 0.
//   - table_o and ones_cnt keep the partial results; the aborted SAMPLE is not written.
//  abort and start together in IDLE: abort wins, nothing starts.
//  rst_n low mid-sweep clears everything asynchronously; no done pulse follows.
// CONFIGURATION
//  FUNC_SWEEP_SELFCHECK_EN defined: adds three ports.
//   - expect_i in 2^N_IN: golden table, sampled at start.
//   - mismatch out 1: sticky per sweep, cleared at start.
//   - first_bad out N_IN: vector index of the first differing SAMPLE; reset 0.
//   - Both outputs are valid from the done cycle. Latency and all other behaviour unchanged.
//  Undefined: none of these ports or registers exist.
// STRUCTURE
//  Shared include func_sweep_defs.vh holds:
//   - state encodings (IDLE=0, WAIT=1, SAMPLE=2, DONE=3, 2-bit)
//   - width helper localparams (NVEC = 1<<N_IN)
//   - default SETTLE
//  One sub-module is natural: func_sweep_timer, the SETTLE down-counter with load/zero flag.
//  FSM, vector register and table capture stay in the top level.
// TESTING (bench drives f_i from a model of e = a&b | c&d on vec_o)
//  1. Reset, pulse start:
//     -> 16 vectors 0..15 each held 2 cycles; done at edge 32;
//        table_o=16'hF888, ones_cnt=7, busy falls the edge after done.
//  2. Model f_i=0, then f_i=1 in back-to-back sweeps:
//     -> 16'h0000/ones_cnt=0, then 16'hFFFF/ones_cnt=16 (width boundary).
//  3. start re-pulsed at vec_o=5 and again in the DONE cycle:
//     -> ignored; single done, results as test 1.
//  4. abort while vec_o=8 in WAIT:
//     -> IDLE next edge, no done, table_o=16'h0088, ones_cnt=2;
//        a new start clears them and completes normally.
//  5. rst_n low mid-sweep (vec_o=10) for a partial cycle:
//     -> all outputs 0 immediately; no done after release.
//  6. SELFCHECK_EN, expect_i=16'hF888 with model bit 7 flipped:
//     -> mismatch=1, first_bad=7 at done; correct model gives mismatch=0.

Source files
------------

// File: rtl/func_sweep_ctrl_pkg.sv
// Shared definitions for the function-sweep sequencer: state encoding, vector-count helper, default settle time.
// Optional self-check feature is enabled with FUNC_SWEEP_SELFCHECK_EN (see func_sweep_ctrl.sv).
package func_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_SETTLE = 1;

    function automatic int nvec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/func_sweep_ctrl_if.sv
// Host-side bundle of the sweep sequencer: start/abort control, status and the captured truth table.
// With FUNC_SWEEP_SELFCHECK_EN defined it also carries the golden table and the mismatch results.
interface func_sweep_ctrl_if
    import func_sweep_ctrl_pkg::*;
#(
    parameter int N_IN = 4
);
    localparam int NV = nvec(N_IN);

    logic            start;
    logic            abort;
    logic            busy;
    logic            done;
    logic [NV-1:0]   table_o;
    logic [N_IN:0]   ones_cnt;
`ifdef FUNC_SWEEP_SELFCHECK_EN
    logic [NV-1:0]   expect_i;
    logic            mismatch;
    logic [N_IN-1:0] first_bad;

    modport master (output start, output abort, output expect_i,
                    input busy, input done, input table_o, input ones_cnt,
                    input mismatch, input first_bad);
    modport slave  (input start, input abort, input expect_i,
                    output busy, output done, output table_o, output ones_cnt,
                    output mismatch, output first_bad);
`else
    modport master (output start, output abort,
                    input busy, input done, input table_o, input ones_cnt);
    modport slave  (input start, input abort,
                    output busy, output done, output table_o, output ones_cnt);
`endif

endinterface

// File: rtl/func_sweep_ctrl_timer.sv
// Settle-window down-counter: loads SETTLE-1, counts down while enabled and parks at zero.
module func_sweep_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_zero
);
    localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= W'(SETTLE - 1);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/func_sweep_ctrl.sv
// Sweeps a combinational function unit through all 2^N_IN input vectors and captures its truth table.
// Define FUNC_SWEEP_SELFCHECK_EN to compare the capture against a golden table loaded at start.
module func_sweep_ctrl
    import func_sweep_ctrl_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    func_sweep_ctrl_if.slave host,
    output logic [N_IN-1:0]  o_vec,
    input  logic             i_f
);
    localparam int NV = nvec(N_IN);

    state_t          r_state;
    logic [N_IN-1:0] r_vec;
    logic            r_busy;
    logic            r_done;
    logic [NV-1:0]   r_table;
    logic [N_IN:0]   r_ones;

    logic w_zero;
    logic w_last;
    logic w_startOk;
    logic w_sampleWr;
    logic w_load;
    logic w_en;

    // abort outranks start, so a simultaneous pair leaves the block idle
    assign w_startOk  = (r_state == IDLE) && host.start && !host.abort;
    assign w_sampleWr = (r_state == SAMPLE) && !host.abort;
    assign w_last     = &r_vec;
    assign w_load     = w_startOk || (w_sampleWr && !w_last);
    assign w_en       = (r_state == WAIT);

    func_sweep_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_en   (w_en),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= '0;
            r_ones  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_startOk) begin
                        r_vec   <= '0;
                        r_table <= '0;
                        r_ones  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (host.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_zero) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (host.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_table[r_vec] <= i_f;
                        r_ones         <= r_ones + {{N_IN{1'b0}}, i_f};
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_vec   <= r_vec + N_IN'(1);
                            r_state <= WAIT;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_vec         = r_vec;
    assign host.busy     = r_busy;
    assign host.done     = r_done;
    assign host.table_o  = r_table;
    assign host.ones_cnt = r_ones;

`ifdef FUNC_SWEEP_SELFCHECK_EN
    logic [NV-1:0]   r_expect;
    logic            r_mismatch;
    logic [N_IN-1:0] r_firstBad;

    // only the first differing vector is recorded; later ones just keep the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_expect   <= '0;
            r_mismatch <= 1'b0;
            r_firstBad <= '0;
        end else if (w_startOk) begin
            r_expect   <= host.expect_i;
            r_mismatch <= 1'b0;
            r_firstBad <= '0;
        end else if (w_sampleWr && (i_f != r_expect[r_vec]) && !r_mismatch) begin
            r_mismatch <= 1'b1;
            r_firstBad <= r_vec;
        end
    end

    assign host.mismatch  = r_mismatch;
    assign host.first_bad = r_firstBad;
`endif

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Scoreboard bench for func_sweep_ctrl: a behavioural function model drives f_i, a monitor checks each done.
// Covers the FUNC_SWEEP_SELFCHECK_EN ports as well when that macro is defined.
module tb_func_sweep_ctrl;

    localparam int N  = 4;
    localparam int S  = 1;
    localparam int NV = 1 << N;
    localparam int SWEEP_EDGES = NV * (S + 1);

    typedef struct {
        logic [NV-1:0] tbl;
        int            ones;
        int            lat;
        logic          mism;
        int            fb;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] vecO;
    logic         fIn;

    int            fMode = 0;
    logic [NV-1:0] randTbl = '0;
    int            total = 0;
    int            bad = 0;
    int            cycleCnt = 0;
    int            startCycle = 0;
    int            doneCount = 0;
    exp_t          expQ[$];

    func_sweep_ctrl_if #(.N_IN(N)) hostIf ();

    func_sweep_ctrl #(.N_IN(N), .SETTLE(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (hostIf),
        .o_vec (vecO),
        .i_f   (fIn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // e = a&b | c&d with {a,b,c,d} = vec, plus constant, random and bit-7-flipped variants
    function automatic logic modelBit(input int mode, input logic [NV-1:0] rt, input int v);
        logic a, b, c, d, e;
        a = v[3]; b = v[2]; c = v[1]; d = v[0];
        e = (a & b) | (c & d);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return rt[v];
            4:       return e ^ (v == 7);
            default: return e;
        endcase
    endfunction

    function automatic logic [NV-1:0] modelTable(input int mode, input logic [NV-1:0] rt, input int lastVec);
        logic [NV-1:0] t = '0;
        for (int v = 0; v <= lastVec; v++) t[v] = modelBit(mode, rt, v);
        return t;
    endfunction

    function automatic int modelOnes(input int mode, input logic [NV-1:0] rt, input int lastVec);
        int n = 0;
        for (int v = 0; v <= lastVec; v++) n += int'(modelBit(mode, rt, v));
        return n;
    endfunction

    always_comb fIn = modelBit(fMode, randTbl, int'(vecO));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (hostIf.done === 1'b1) begin
            doneCount++;
            checkOutput("doneExpected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("table", 32'(hostIf.table_o), 32'(e.tbl));
                checkOutput("onesCnt", 32'(hostIf.ones_cnt), 32'(e.ones));
                checkOutput("latency", 32'(cycleCnt - startCycle), 32'(e.lat));
`ifdef FUNC_SWEEP_SELFCHECK_EN
                checkOutput("mismatch", 32'(hostIf.mismatch), 32'(e.mism));
                checkOutput("firstBad", 32'(hostIf.first_bad), 32'(e.fb));
`endif
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // full sweep: pushes the expected result, then tracks vec_o/busy cycle by cycle
    task automatic applyStimulus(input int mode, input bit repulse, input logic [NV-1:0] expTbl,
                                 input int expOnes, input logic [NV-1:0] golden);
        exp_t e;
        int vecErr = 0;
        int busyErr = 0;
        int expVec;
        e.tbl = expTbl; e.ones = expOnes; e.lat = SWEEP_EDGES; e.mism = 1'b0; e.fb = 0;
        for (int v = NV - 1; v >= 0; v--) begin
            if (modelBit(mode, randTbl, v) != golden[v]) begin
                e.mism = 1'b1;
                e.fb = v;
            end
        end
`ifdef FUNC_SWEEP_SELFCHECK_EN
        hostIf.expect_i = golden;
`endif
        fMode = mode;
        expQ.push_back(e);
        @(negedge clk);
        hostIf.start = 1'b1;
        @(negedge clk);
        hostIf.start = 1'b0;
        startCycle = cycleCnt;
        for (int k = 0; k <= SWEEP_EDGES + 1; k++) begin
            if (k > 0) @(negedge clk);
            hostIf.start = 1'b0;
            expVec = (k / (S + 1) > NV - 1) ? NV - 1 : k / (S + 1);
            if (int'(vecO) != expVec) vecErr++;
            if (hostIf.busy !== (k <= SWEEP_EDGES)) busyErr++;
            if (repulse && (k == 5 * (S + 1) || k == SWEEP_EDGES)) hostIf.start = 1'b1;
        end
        hostIf.start = 1'b0;
        checkOutput("vecSeq", 32'(vecErr), 32'd0);
        checkOutput("busySeq", 32'(busyErr), 32'd0);
        checkOutput("doneSeen", 32'(expQ.size()), 32'd0);
    endtask

    task automatic startAndWaitVec(input int target, output bit found);
        found = 1'b0;
        fMode = 0;
        @(negedge clk);
        hostIf.start = 1'b1;
        @(negedge clk);
        hostIf.start = 1'b0;
        for (int k = 0; k < 4 * SWEEP_EDGES && !found; k++) begin
            if (int'(vecO) == target) found = 1'b1;
            else @(negedge clk);
        end
        checkOutput("reachVec", 32'(found), 32'd1);
    endtask

    initial begin
        int  prevDone;
        bit  found;
        hostIf.start = 1'b0;
        hostIf.abort = 1'b0;
`ifdef FUNC_SWEEP_SELFCHECK_EN
        hostIf.expect_i = '0;
`endif
        #12;
        checkOutput("rstVec", 32'(vecO), 32'd0);
        checkOutput("rstBusy", 32'(hostIf.busy), 32'd0);
        checkOutput("rstDone", 32'(hostIf.done), 32'd0);
        checkOutput("rstTable", 32'(hostIf.table_o), 32'd0);
        checkOutput("rstOnes", 32'(hostIf.ones_cnt), 32'd0);
        rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] basic sweep of e = a&b | c&d");
        applyStimulus(0, 1'b0, 16'hF888, 7, 16'hF888);
        idleCycles(2);
        checkOutput("holdTable", 32'(hostIf.table_o), 32'h0000F888);
        checkOutput("holdVec", 32'(vecO), 32'(NV - 1));

        $display("[TB] constant-zero and constant-one sweeps");
        applyStimulus(1, 1'b0, modelTable(1, randTbl, NV - 1), modelOnes(1, randTbl, NV - 1), '0);
        applyStimulus(2, 1'b0, modelTable(2, randTbl, NV - 1), modelOnes(2, randTbl, NV - 1), '1);
        checkOutput("onesFull", 32'(hostIf.ones_cnt), 32'(NV));

        $display("[TB] start re-pulsed mid-sweep and during done");
        prevDone = doneCount;
        applyStimulus(0, 1'b1, 16'hF888, 7, 16'hF888);
        idleCycles(SWEEP_EDGES + 8);
        checkOutput("singleDone", 32'(doneCount - prevDone), 32'd1);
        checkOutput("idleBusy", 32'(hostIf.busy), 32'd0);

        $display("[TB] random function tables");
        for (int i = 0; i < 4; i++) begin
            randTbl = NV'($urandom);
            applyStimulus(3, 1'b0, modelTable(3, randTbl, NV - 1), modelOnes(3, randTbl, NV - 1),
                          modelTable(3, randTbl, NV - 1));
        end

        $display("[TB] abort while vector 8 is settling");
        prevDone = doneCount;
        startAndWaitVec(8, found);
        hostIf.abort = 1'b1;
        @(negedge clk);
        hostIf.abort = 1'b0;
        checkOutput("abortBusy", 32'(hostIf.busy), 32'd0);
        checkOutput("abortTable", 32'(hostIf.table_o), 32'(modelTable(0, randTbl, 7)));
        checkOutput("abortOnes", 32'(hostIf.ones_cnt), 32'(modelOnes(0, randTbl, 7)));
        idleCycles(SWEEP_EDGES + 8);
        checkOutput("abortNoDone", 32'(doneCount - prevDone), 32'd0);
        applyStimulus(0, 1'b0, 16'hF888, 7, 16'hF888);

        $display("[TB] start and abort together in idle");
        @(negedge clk);
        hostIf.start = 1'b1;
        hostIf.abort = 1'b1;
        @(negedge clk);
        hostIf.start = 1'b0;
        hostIf.abort = 1'b0;
        checkOutput("abortWinsBusy", 32'(hostIf.busy), 32'd0);
        checkOutput("abortWinsTable", 32'(hostIf.table_o), 32'h0000F888);

        $display("[TB] asynchronous reset mid-sweep");
        prevDone = doneCount;
        startAndWaitVec(10, found);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arstVec", 32'(vecO), 32'd0);
        checkOutput("arstBusy", 32'(hostIf.busy), 32'd0);
        checkOutput("arstTable", 32'(hostIf.table_o), 32'd0);
        checkOutput("arstOnes", 32'(hostIf.ones_cnt), 32'd0);
        #1 rst_n = 1'b1;
        idleCycles(SWEEP_EDGES + 8);
        checkOutput("arstNoDone", 32'(doneCount - prevDone), 32'd0);
        checkOutput("arstIdleBusy", 32'(hostIf.busy), 32'd0);

`ifdef FUNC_SWEEP_SELFCHECK_EN
        $display("[TB] golden-table compare with bit 7 flipped");
        applyStimulus(4, 1'b0, modelTable(4, randTbl, NV - 1), modelOnes(4, randTbl, NV - 1), 16'hF888);
        applyStimulus(0, 1'b0, 16'hF888, 7, 16'hF888);
`endif

        idleCycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
